shared_register_arbiter: RTL



---
 rtl/shared_reg_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/shared_register_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding
// and default sizing.
package shared_reg_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at
// or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  sel,
  output logic [N_REQ-1:0] onehot
);

  // Scan from the farthest candidate back to ptr so the last hit wins,
  // leaving the nearest request at or after ptr selected.
  always_comb begin
    int idx;
    valid  = 1'b0;
    sel    = '0;
    onehot = '0;
    idx    = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (req[idx]) begin
        valid       = 1'b1;
        sel         = ID_W'(idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_register_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit storage register between N_REQ
// requesters. One write at a time: IDLE -> GRANT -> ACK -> IDLE.
module shared_register_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qbar,
  output logic                   busy,
  output logic [ID_W-1:0]        owner_id
);

  state_t             state_q;
  logic [ID_W-1:0]    sel_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    owner_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   ack_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   data_d;
  logic               wr_en;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_sel;
  logic [N_REQ-1:0]   pick_onehot;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .valid  (pick_valid),
    .sel    (pick_sel),
    .onehot (pick_onehot)
  );

  // Write happens only if the granted requester still holds req on the
  // GRANT edge; its data is sampled at that edge and nowhere else.
  always_comb begin
    wr_en  = (state_q == ST_GRANT) && req[sel_q];
    data_d = wdata[int'(sel_q)*WIDTH +: WIDTH];
  end

  // Shared storage register: WIDTH D flip-flops with enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (wr_en) begin
      data_q <= data_d;
    end
  end

  // Arbitration FSM with registered grant/ack and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_onehot;
            sel_q   <= pick_sel;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          gnt_q <= '0;
          if (wr_en) begin
            ack_q   <= gnt_q;
            owner_q <= sel_q;
            state_q <= ST_ACK;
          end else begin
            // Withdrawn request: no write, pointer left where it was.
            state_q <= ST_IDLE;
          end
        end
        ST_ACK: begin
          ack_q <= '0;
          if (sel_q == ID_W'(N_REQ - 1)) begin
            rr_ptr_q <= '0;
          end else begin
            rr_ptr_q <= sel_q + 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign q        = data_q;
  assign qbar     = ~data_q;
  assign busy     = (state_q != ST_IDLE);
  assign owner_id = owner_q;

endmodule
